// File: rtl/mulf_pkg.sv
// rtl/mulf_pkg.sv - shared constants, class decode and flag indices for the multiplier round/pack stage
package mulf_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 2 * BIAS + 1;

    localparam int CLS_A_NAN  = 5;
    localparam int CLS_A_INF  = 4;
    localparam int CLS_A_ZERO = 3;
    localparam int CLS_B_NAN  = 2;
    localparam int CLS_B_INF  = 1;
    localparam int CLS_B_ZERO = 0;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [1:0] {
        SPEC_NONE,
        SPEC_NAN,
        SPEC_INF,
        SPEC_ZERO
    } spec_e;

    // Priority: NaN/invalid beats inf beats zero.
    function automatic spec_e decode_cls(input logic [5:0] cls);
        logic any_nan;
        logic any_inf;
        logic any_zero;
        logic inf_x_zero;
        any_nan    = cls[CLS_A_NAN] | cls[CLS_B_NAN];
        any_inf    = cls[CLS_A_INF] | cls[CLS_B_INF];
        any_zero   = cls[CLS_A_ZERO] | cls[CLS_B_ZERO];
        inf_x_zero = (cls[CLS_A_INF] & cls[CLS_B_ZERO]) | (cls[CLS_B_INF] & cls[CLS_A_ZERO]);
        if (any_nan || inf_x_zero) return SPEC_NAN;
        if (any_inf)               return SPEC_INF;
        if (any_zero)              return SPEC_ZERO;
        return SPEC_NONE;
    endfunction

endpackage

// File: rtl/mulf_rne.sv
// rtl/mulf_rne.sv - round-to-nearest-even increment of a 23-bit fraction with exponent carry
module mulf_rne #(
    parameter int EW = 11
) (
    input  logic [22:0]          m,
    input  logic                 g,
    input  logic                 st,
    input  logic signed [EW-1:0] e,
    output logic [22:0]          mant,
    output logic signed [EW-1:0] e_rounded,
    output logic                 carry
);

    logic        inc;
    logic [23:0] sum;

    assign inc       = g & (st | m[0]);
    assign sum       = {1'b0, m} + {23'h0, inc};
    assign carry     = sum[23];
    assign mant      = sum[22:0];
    assign e_rounded = e + {{(EW-1){1'b0}}, carry};

endmodule

// File: rtl/mulf_round_pack.sv
// rtl/mulf_round_pack.sv - 2-stage normalize/round/pack to binary32; MULF_FLAGS_EN adds out_flags
module mulf_round_pack #(
    parameter int          EXPW = 10,
    parameter logic [31:0] QNAN = mulf_pkg::QNAN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic signed [EXPW-1:0] in_exp,
    input  logic [47:0]            in_prod,
    input  logic [5:0]             in_cls,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef MULF_FLAGS_EN
    output logic [3:0]             out_flags,
`endif
    output logic [31:0]            out_s
);

    import mulf_pkg::*;

    localparam logic signed [EXPW:0] E_ONE = 1;

    logic                 s2_adv;
    logic signed [EXPW:0] exp_ext;
    logic signed [EXPW:0] n_e;
    logic [22:0]          n_m;
    logic                 n_g;
    logic                 n_st;

    logic                 s1_valid;
    logic                 s1_sign;
    logic [22:0]          s1_m;
    logic                 s1_g;
    logic                 s1_st;
    logic signed [EXPW:0] s1_e;
    spec_e                s1_cls;

    logic [22:0]          rnd_mant;
    logic signed [EXPW:0] rnd_e;
    logic                 rnd_carry;
    logic [22:0]          fin_mant;
    logic [31:0]          res_s;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    assign exp_ext = {in_exp[EXPW-1], in_exp};

    always_comb begin
        if (in_prod[47]) begin
            n_m  = in_prod[46:24];
            n_g  = in_prod[23];
            n_st = |in_prod[22:0];
            n_e  = exp_ext + E_ONE;
        end else begin
            n_m  = in_prod[45:23];
            n_g  = in_prod[22];
            n_st = |in_prod[21:0];
            n_e  = exp_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_m     <= '0;
            s1_g     <= 1'b0;
            s1_st    <= 1'b0;
            s1_e     <= '0;
            s1_cls   <= SPEC_NONE;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_m    <= n_m;
                s1_g    <= n_g;
                s1_st   <= n_st;
                s1_e    <= n_e;
                s1_cls  <= decode_cls(in_cls);
            end
        end
    end

    mulf_rne #(.EW(EXPW + 1)) u_rne (
        .m         (s1_m),
        .g         (s1_g),
        .st        (s1_st),
        .e         (s1_e),
        .mant      (rnd_mant),
        .e_rounded (rnd_e),
        .carry     (rnd_carry)
    );

    // A carry-out means the significand wrapped to 1.000..., so the fraction is zero.
    assign fin_mant = rnd_carry ? 23'h0 : rnd_mant;

`ifdef MULF_FLAGS_EN
    logic [3:0] res_flags;
`endif

    always_comb begin
        res_s = '0;
`ifdef MULF_FLAGS_EN
        res_flags = '0;
`endif
        case (s1_cls)
            SPEC_NAN: begin
                res_s = QNAN;
`ifdef MULF_FLAGS_EN
                res_flags[FLG_INVALID] = 1'b1;
`endif
            end
            SPEC_INF:  res_s = {s1_sign, 8'hFF, 23'h0};
            SPEC_ZERO: res_s = {s1_sign, 31'h0};
            default: begin
                if (rnd_e >= EXP_MAX) begin
                    res_s = {s1_sign, 8'hFF, 23'h0};
`ifdef MULF_FLAGS_EN
                    res_flags[FLG_OVERFLOW] = 1'b1;
                    res_flags[FLG_INEXACT]  = 1'b1;
`endif
                end else if (rnd_e <= 0) begin
                    res_s = {s1_sign, 31'h0};
`ifdef MULF_FLAGS_EN
                    res_flags[FLG_UNDERFLOW] = 1'b1;
                    res_flags[FLG_INEXACT]   = 1'b1;
`endif
                end else begin
                    res_s = {s1_sign, rnd_e[7:0], fin_mant};
`ifdef MULF_FLAGS_EN
                    res_flags[FLG_INEXACT] = s1_g | s1_st;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
`ifdef MULF_FLAGS_EN
            out_flags <= '0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_s <= res_s;
`ifdef MULF_FLAGS_EN
                out_flags <= res_flags;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mulf_round_pack.sv
// tb/tb_mulf_round_pack.sv - scoreboard bench for mulf_round_pack (directed vectors, backpressure, reset)
module tb_mulf_round_pack;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] prod;
        logic [5:0]  cls;
        logic [31:0] s;
        logic [3:0]  flags;
    } vec_t;

    localparam int NVEC = 18;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_sign = 1'b0;
    logic signed [9:0]  in_exp = '0;
    logic [47:0]        in_prod = '0;
    logic [5:0]         in_cls = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_s;
`ifdef MULF_FLAGS_EN
    logic [3:0]         out_flags;
`endif

    vec_t        vecs [NVEC];
    logic [35:0] exp_q [$];
    int          cyc_q [$];
    int          cycle = 0;
    bit          lat_chk = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          sent = 0;
    int          rcvd = 0;
    logic [35:0] mon_e;
    int          mon_c;
    int          t0;
    int          base;
    logic [31:0] hold_s;

    mulf_round_pack #(.EXPW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_prod   (in_prod),
        .in_cls    (in_cls),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MULF_FLAGS_EN
        .out_flags (out_flags),
`endif
        .out_s     (out_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_prod  = v.prod;
        in_cls   = v.cls;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (in_ready) begin
            exp_q.push_back({v.flags, v.s});
            cyc_q.push_back(cycle);
            sent++;
        end else begin
            check_val("accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out", out_s, 32'hxxxxxxxx);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = cyc_q.pop_front();
                check_val($sformatf("out_s[%0d]", rcvd), out_s, mon_e[31:0]);
`ifdef MULF_FLAGS_EN
                check_val($sformatf("flags[%0d]", rcvd), {28'h0, out_flags}, {28'h0, mon_e[35:32]});
`endif
                if (lat_chk) check_val("latency", cycle - mon_c, 2);
                rcvd++;
            end
        end
    end

    initial begin
        //            sign  exp      prod              cls        result        flags
        vecs[0]  = '{1'b0, 10'd127, 48'h900000000000, 6'b000000, 32'h40100000, 4'b0000};
        vecs[1]  = '{1'b0, 10'd127, 48'h800001800000, 6'b000000, 32'h40000002, 4'b0001};
        vecs[2]  = '{1'b0, 10'd127, 48'h800000800000, 6'b000000, 32'h40000000, 4'b0001};
        vecs[3]  = '{1'b0, 10'd127, 48'hFFFFFFFFFFFF, 6'b000000, 32'h40800000, 4'b0001};
        vecs[4]  = '{1'b1, 10'd254, 48'h800000000000, 6'b000000, 32'hFF800000, 4'b0101};
        vecs[5]  = '{1'b0, 10'h3FF, 48'h400000000000, 6'b000000, 32'h00000000, 4'b0011};
        vecs[6]  = '{1'b0, 10'd254, 48'hFFFFFFFFFFFF, 6'b010001, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{1'b1, 10'd127, 48'h900000000000, 6'b001000, 32'h80000000, 4'b0000};
        vecs[8]  = '{1'b0, 10'd127, 48'h900000000000, 6'b000010, 32'h7F800000, 4'b0000};
        vecs[9]  = '{1'b0, 10'd1,   48'h400000000000, 6'b000000, 32'h00800000, 4'b0000};
        vecs[10] = '{1'b0, 10'd0,   48'h7FFFFFFFFFFF, 6'b000000, 32'h00800000, 4'b0001};
        vecs[11] = '{1'b0, 10'd254, 48'h7FFFFFFFFFFF, 6'b000000, 32'h7F800000, 4'b0101};
        vecs[12] = '{1'b0, 10'd127, 48'h800000000001, 6'b000000, 32'h40000000, 4'b0001};
        vecs[13] = '{1'b1, 10'd127, 48'h900000000000, 6'b100010, 32'h7FC00000, 4'b1000};
        vecs[14] = '{1'b1, 10'd0,   48'h400000000000, 6'b000000, 32'h80000000, 4'b0011};
        vecs[15] = '{1'b0, 10'd253, 48'hC00000000000, 6'b000000, 32'h7F400000, 4'b0000};
        vecs[16] = '{1'b0, 10'd383, 48'h400000000000, 6'b000000, 32'h7F800000, 4'b0101};
        vecs[17] = '{1'b0, 10'd5,   48'h800000000000, 6'b001010, 32'h7FC00000, 4'b1000};

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_s", out_s, 0);
`ifdef MULF_FLAGS_EN
        check_val("rst_flags", out_flags, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with no backpressure: fixed latency and one result per cycle.
        lat_chk = 1'b1;
        t0 = cycle;
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        check_val("throughput", cycle - t0, NVEC);
        drain();
        lat_chk = 1'b0;

        // Backpressure: two entries fill the pipe, the rest stall until released.
        out_ready = 1'b0;
        base = sent;
        fork
            begin
                for (int i = 0; i < 4; i++) send(vecs[i]);
            end
        join_none
        repeat (6) @(negedge clk);
        check_val("bp_in_ready", in_ready, 0);
        check_val("bp_accepted", sent - base, 2);
        check_val("bp_out_valid", out_valid, 1);
        check_val("bp_out_s", out_s, vecs[0].s);
        hold_s = out_s;
        repeat (3) @(negedge clk);
        check_val("bp_hold", out_s, hold_s);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();
        check_val("bp_count", sent - base, 4);

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        send(vecs[1]);
        send(vecs[3]);
        check_val("full_in_ready", in_ready, 0);
        check_val("full_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_out_valid", out_valid, 0);
        check_val("async_in_ready", in_ready, 1);
        check_val("async_out_s", out_s, 0);
        exp_q.delete();
        cyc_q.delete();
        sent = sent - 2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_val("post_rst_idle", out_valid, 0);
        @(posedge clk);
        #1;
        send(vecs[4]);
        drain();

        check_val("total_count", rcvd, sent);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mulf_round_pack.md
Name: mulf_round_pack

Overview:
- Pipelined normalize/round/pack stage that sits directly downstream of the single-precision float multiplier datapath.
- Consumes the raw 48-bit significand product, the pre-biased exponent sum, the sign and the operand class bits.
- Produces an IEEE-754 binary32 result using round-to-nearest-even, with ±inf on overflow and flush-to-zero on underflow.
- Elastic 2-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- EXPW, 10, width of the signed exponent-sum input; must hold the range -127..383.
- QNAN, 32'h7FC00000, canonical quiet NaN emitted for invalid cases.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream holds a valid operation.
- in_ready  output  1  stage can accept an operation this cycle.
- in_sign  input  1  result sign (asign ^ bsign).
- in_exp  input  EXPW  signed value aexp + bexp - 127.
- in_prod  input  48  amant*bmant with implicit 1s included; value lies in [2^46, 2^48).
- in_cls  input  6  {a_nan, a_inf, a_zero, b_nan, b_inf, b_zero}.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_s  output  32  packed binary32 result.

Behaviour:
- Reset: out_valid=0, out_s=0, both stage valid bits=0, in_ready=1. Reset asserted mid-operation discards all in-flight entries.
- Transfers occur when valid&ready are both high on a clock edge.
- Latency is exactly 2 cycles from input acceptance to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Ready propagation:
  - s2 advances when !s2_valid || out_ready.
  - in_ready = !s1_valid || s2 advances.
  - This is combinational through the stages; there is no bubble when out_ready=1.
- While out_valid=1 and out_ready=0, out_s is held stable. Order is always preserved.
- Stage 1 (normalize):
  - If in_prod[47]=1: m=in_prod[46:24], g=in_prod[23], st=|in_prod[22:0], e=in_exp+1.
  - Otherwise: m=in_prod[45:23], g=in_prod[22], st=|in_prod[21:0], e=in_exp.
  - Special-case class is decoded here and registered.
- Stage 2 (round/pack):
  - inc = g & (st | m[0]). The 24-bit sum {0,m}+inc; on carry-out the mantissa becomes 0 and e+1.
  - e>=255 after rounding: out_s={sign,8'hFF,23'h0}.
  - e<=0: out_s={sign,31'h0} (flush to zero).
  - Otherwise: out_s={sign,e[7:0],mant[22:0]}.
- Special-case priority, highest first, overriding arithmetic:
  1. Any NaN, or inf×zero: out_s=QNAN.
  2. Any inf: out_s={sign,8'hFF,23'h0}.
  3. Any zero: out_s={sign,31'h0}.
  - In all special cases in_prod and in_exp are ignored.
- Exponent arithmetic is signed EXPW+1 bits internally, so intermediate values never wrap.

Optional Feature:
- Macro MULF_FLAGS_EN.
- When defined:
  - Adds output port out_flags[3:0] = {invalid, overflow, underflow, inexact}, aligned with out_s and reset to 0.
  - invalid: the NaN/inf×zero case.
  - overflow: the e>=255 result.
  - underflow: a flushed nonzero result.
  - inexact: g|st on the arithmetic path, also set on overflow and underflow.
- When undefined: the port is absent and the flag logic is not synthesised. out_s behaviour is identical in both builds.

Decomposition:
- Package mulf_pkg holds:
  - QNAN, BIAS=127 and EXP_MAX=255 constants.
  - Class-bit index constants.
  - Flag bit index constants.
- One sub-module, mulf_rne: combinational, takes {m,g,st,e} and returns {mant, e_rounded, carry}; instantiated in stage 2.

Test Plan:
- 1.5×1.5: in_exp=127, in_prod=48'h900000000000, sign=0 -> out_s=32'h40100000 exactly 2 cycles later.
- Tie, LSB odd: in_exp=127, in_prod=48'h800001800000 -> 32'h40000002. Tie, LSB even: in_prod=48'h800000800000 -> 32'h40000000.
- Rounding carry: in_prod=48'hFFFFFFFFFFFF, in_exp=127 -> 32'h40800000. Overflow: in_exp=254, in_prod[47]=1, sign=1 -> 32'hFF800000. Underflow: in_exp=-1 -> 32'h00000000 (underflow flag set with MULF_FLAGS_EN).
- Specials: a_inf with b_zero -> 32'h7FC00000; a_zero only, sign=1 -> 32'h80000000; b_inf only -> 32'h7F800000.
- Backpressure: 4 back-to-back inputs with out_ready=0 -> in_ready drops after 2 are accepted and out_s stays stable. Releasing out_ready -> 4 results emitted in order with no loss or duplication.
- Reset: assert rst_n=0 with both stages full -> out_valid=0 and in_ready=1 immediately (asynchronously); no stale result appears after release.
